// File: rtl/alsaqr_valrdy_to_credit_fifo.sv
// Valid/ready to credit-based flit bridge: buffers upstream flits and sends one per edge while credits remain.
// Push-to-valid_out latency is one edge when the flit lands at the head; ready_in is registered and drops when full.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module alsaqr_valrdy_to_credit_fifo #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int CREDITS    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             valid_in,
  output logic                             ready_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid_out,
  input  logic                             yummy_out,
  output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_cnt,
  output logic                             credit_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  ready_q, ready_d;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q, err_d;
  logic                  push, pop;

  always_comb begin
    push     = valid_in && ready_q;
    pop      = (cnt_q != '0) && (credit_q != '0);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + NW'(push) - NW'(pop);
    // ready depends on the post-edge occupancy only, so a full buffer never passes through
    ready_d  = cnt_d < DEPTH_N;
    credit_d = credit_q;
    err_d    = err_q;
    if (pop && !yummy_out) begin
      credit_d = credit_q - CW'(1);
    end else if (yummy_out && !pop) begin
      if (credit_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      credit_q <= CRED_MAX;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      ready_q  <= ready_d;
      valid_q  <= pop;
      err_q    <= err_d;
      if (pop) begin
        data_q <= mem[rd_ptr_q];
      end
    end
  end

  // storage is never reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign ready_in   = ready_q;
  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign credit_cnt = credit_q;
  assign fifo_cnt   = cnt_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_alsaqr_valrdy_to_credit_fifo.sv
// Bench for the val/rdy to credit bridge: queue-based reference model plus directed scenarios.
module tb_alsaqr_valrdy_to_credit_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CRED  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          yummy_out = 1'b0;
  logic [3:0]    credit_cnt;
  logic [4:0]    fifo_cnt;
  logic          credit_err;

  int errors = 0;
  int checks = 0;

  alsaqr_valrdy_to_credit_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CREDITS(CRED)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .yummy_out(yummy_out), .credit_cnt(credit_cnt), .fifo_cnt(fifo_cnt),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered flits and an integer credit pool.
  logic [DW-1:0] mq[$];
  int            m_cred = CRED;
  logic          m_ready = 1'b0;
  logic          m_vout = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic          m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_cred  = CRED;
      m_ready = 1'b0;
      m_vout  = 1'b0;
      m_dout  = '0;
      m_err   = 1'b0;
    end else begin
      bit do_push, do_pop;
      do_push = valid_in && m_ready;
      do_pop  = (mq.size() > 0) && (m_cred > 0);
      if (do_pop) m_dout = mq.pop_front();
      m_vout = do_pop;
      if (do_push) mq.push_back(data_in);
      if (do_pop && !yummy_out) m_cred = m_cred - 1;
      else if (yummy_out && !do_pop) begin
        if (m_cred == CRED) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
      m_ready = mq.size() < DEPTH;
    end
  end

  always @(negedge clk) begin
    chk("ready_in",   ready_in,   m_ready);
    chk("valid_out",  valid_out,  m_vout);
    chk("data_out",   data_out,   m_dout);
    chk("credit_cnt", credit_cnt, m_cred);
    chk("fifo_cnt",   fifo_cnt,   mq.size());
    chk("credit_err", credit_err, m_err);
  end

  // Every flit seen on the credit side, in arrival order.
  logic [DW-1:0] log_q[$];
  always @(negedge clk) if (valid_out) log_q.push_back(data_out);

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic y);
    @(negedge clk);
    valid_in  = v;
    data_in   = d;
    yummy_out = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0; yummy_out = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    log_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcnt;
    logic [DW-1:0] d;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready",  ready_in,   1'b0);
    chk("rst_valid",  valid_out,  1'b0);
    chk("rst_data",   data_out,   16'h0);
    chk("rst_credit", credit_cnt, 4'd8);
    chk("rst_fifo",   fifo_cnt,   5'd0);
    chk("rst_err",    credit_err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", ready_in, 1'b1);

    // ten flits, eight credits
    for (int i = 1; i <= 10; i++) cyc(1'b1, 16'(i), 1'b0);
    idle(3);
    chk("A_credit", credit_cnt, 4'd0);
    chk("A_fifo",   fifo_cnt,   5'd2);
    chk("A_logsz",  log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk("A_order", log_q[i], 16'(i + 1));
    cyc(1'b0, '0, 1'b1);
    idle(3);
    chk("A_logsz9", log_q.size(), 9);
    if (log_q.size() == 9) chk("A_flit9", log_q[8], 16'h9);
    chk("A_credit2", credit_cnt, 4'd0);
    chk("A_fifo2",   fifo_cnt,   5'd1);

    // fill to full with no credits, 17th flit held upstream
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h10 + 16'(i), 1'b0);
    idle(2);
    chk("B_credit0", credit_cnt, 4'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h100 + 16'(i), 1'b0);
    chk("B_full_cnt",   fifo_cnt, 5'd16);
    chk("B_full_ready", ready_in, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0117, 1'b0);
    chk("B_held_cnt", fifo_cnt, 5'd16);
    cyc(1'b1, 16'h0117, 1'b1);
    cyc(1'b1, 16'h0117, 1'b0);
    chk("B_pop_cnt",   fifo_cnt, 5'd15);
    chk("B_pop_ready", ready_in, 1'b1);
    cyc(1'b1, 16'h0117, 1'b0);
    chk("B_refill_cnt", fifo_cnt, 5'd16);
    idle(2);
    chk("B_logsz", log_q.size(), 9);
    if (log_q.size() == 9) chk("B_head", log_q[8], 16'h0100);

    // pop and yummy together at three credits
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 16'h40 + 16'(i), 1'b0);
    idle(2);
    chk("C_credit3", credit_cnt, 4'd3);
    cyc(1'b1, 16'h0055, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("C_credit_hold", credit_cnt, 4'd3);
    chk("C_valid", valid_out, 1'b1);
    chk("C_data",  data_out,  16'h0055);

    // push and pop together at five buffered
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h60 + 16'(i), 1'b0);
    idle(2);
    chk("D_credit0", credit_cnt, 4'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h70 + 16'(i), 1'b0);
    chk("D_fifo4", fifo_cnt, 5'd4);
    cyc(1'b1, 16'h0074, 1'b1);
    chk("D_fifo5", fifo_cnt, 5'd5);
    cyc(1'b1, 16'h0075, 1'b0);
    chk("D_fifo_hold", fifo_cnt, 5'd5);
    chk("D_valid", valid_out, 1'b1);
    chk("D_data",  data_out,  16'h0070);

    // asynchronous reset with six buffered and valid_out high
    cyc(1'b1, 16'h0076, 1'b0);
    cyc(1'b1, 16'h0077, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("G_fifo6",  fifo_cnt,  5'd6);
    chk("G_valid1", valid_out, 1'b1);
    #2;
    reset = 1'b1; valid_in = 1'b0; yummy_out = 1'b0;
    #1;
    chk("G_async_valid",  valid_out,  1'b0);
    chk("G_async_data",   data_out,   16'h0);
    chk("G_async_fifo",   fifo_cnt,   5'd0);
    chk("G_async_credit", credit_cnt, 4'd8);
    chk("G_async_ready",  ready_in,   1'b0);
    chk("G_async_err",    credit_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    @(posedge clk); #1;
    chk("G_ready_rise", ready_in, 1'b1);
    cyc(1'b1, 16'h00AB, 1'b0);
    cyc(1'b1, 16'h00AC, 1'b0);
    idle(3);
    chk("G_logsz", log_q.size(), 2);
    if (log_q.size() == 2) chk("G_first", log_q[0], 16'h00AB);

    // spurious yummy at full credits
    do_reset();
    idle(2);
    cyc(1'b0, '0, 1'b1);
    chk("E_err",    credit_err, 1'b1);
    chk("E_credit", credit_cnt, 4'd8);
    idle(5);
    chk("E_err_sticky", credit_err, 1'b1);
    chk("E_credit2",    credit_cnt, 4'd8);
    chk("E_novalid",    log_q.size(), 0);

    // streaming with a yummy on every pop, across many pointer wraps
    do_reset();
    idle(1);
    vcnt = 0;
    cyc(1'b1, 16'h0200, 1'b0);
    for (int i = 1; i < 100; i++) begin
      d = 16'h0200 + 16'(i);
      cyc(1'b1, d, 1'b1);
      if (valid_out) vcnt++;
    end
    chk("F_rate",    vcnt, 99);
    chk("F_credit8", credit_cnt, 4'd8);
    chk("F_fifo1",   fifo_cnt, 5'd1);
    idle(3);
    chk("F_logsz", log_q.size(), 100);
    for (int i = 0; i < 100 && i < log_q.size(); i++) chk("F_order", log_q[i], 16'h0200 + 16'(i));
    chk("F_err", credit_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alsaqr_valrdy_to_credit_fifo.md
ALSAQR_VALRDY_TO_CREDIT_FIFO -- requirements
Module: alsaqr_valrdy_to_credit_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, flit width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, buffer entries; SHALL be a power of two, >= 2.
REQ-003 Parameter CREDITS, default 8, downstream buffer credits held at reset; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 data_in  input  DATA_WIDTH  val/rdy flit from upstream.
REQ-007 valid_in  input  1  upstream flit valid.
REQ-008 ready_in  output  1  block can accept a flit this cycle.
REQ-009 data_out  output  DATA_WIDTH  credit-side flit.
REQ-010 valid_out  output  1  one-cycle pulse, one flit transferred downstream per pulse.
REQ-011 yummy_out  input  1  one-cycle pulse, downstream returns one credit.
REQ-012 credit_cnt  output  $clog2(CREDITS+1)  credits currently held.
REQ-013 fifo_cnt  output  $clog2(FIFO_DEPTH+1)  flits currently buffered.
REQ-014 credit_err  output  1  sticky: yummy received with no credit outstanding.

Function
REQ-015 Upstream accept ("push") SHALL occur on a rising edge where valid_in && ready_in; data_in written at the write pointer.
REQ-016 ready_in SHALL be registered: 1 after an edge iff the resulting fifo_cnt < FIFO_DEPTH; no pass-through when full, even with a simultaneous pop.
REQ-017 Send ("pop") SHALL occur on a rising edge where fifo_cnt > 0 && credit_cnt > 0; head flit registered to data_out, valid_out = 1 next cycle.
REQ-018 valid_out SHALL be 0 in any cycle following an edge without a pop; data_out SHALL hold its last value when valid_out is 0.
REQ-019 Minimum latency: flit pushed at edge N SHALL appear with valid_out at edge N+1 (visible in the cycle after that edge) only if already at head; otherwise strict FIFO order, no reordering, no drops.
REQ-020 Continuous streaming SHALL be supported: one push and one pop per edge sustained when not full and credits > 0.
REQ-021 fifo_cnt next = fifo_cnt + push - pop; simultaneous push and pop SHALL leave fifo_cnt unchanged.
REQ-022 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-023 credit_cnt next = credit_cnt - pop + yummy_out; pop and yummy on the same edge SHALL leave it unchanged.
REQ-024 Pop with credit_cnt == 1 and no yummy SHALL drive credit_cnt to 0 and block further pops until a yummy arrives.
REQ-025 yummy_out with credit_cnt == CREDITS and no pop SHALL saturate credit_cnt at CREDITS and set credit_err; credit_err clears only on reset.
REQ-026 valid_in while ready_in == 0 SHALL be ignored (no write, no state change).
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 While reset is high: fifo_cnt 0, pointers 0, credit_cnt = CREDITS, valid_out 0, data_out 0, ready_in 0, credit_err 0.
REQ-029 ready_in SHALL rise on the first rising edge after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL immediately force REQ-028 values; buffered flits discarded, in-flight valid_out pulse truncated.
REQ-031 Buffer contents SHALL NOT require reset.

Verification
REQ-032 CREDITS=8, no yummy, push 10 flits 0x1..0xA -> valid_out pulses for 0x1..0x8 in order, credit_cnt 0, fifo_cnt 2; one yummy -> 0x9 sent, credit_cnt 0.
REQ-033 FIFO_DEPTH=16, credit_cnt 0, push 17 flits back-to-back -> ready_in 0 after 16th push, 17th held upstream, fifo_cnt 16; one yummy -> one pop, ready_in 1 next edge.
REQ-034 Yummy returned every cycle, valid_in held high with incrementing data for 100 cycles -> 1 flit/cycle on valid_out after 2-cycle fill, credit_cnt constant, order preserved across pointer wrap.
REQ-035 Idle, credit_cnt = CREDITS, inject one yummy -> credit_err 1 and stays 1, credit_cnt stays CREDITS, no valid_out.
REQ-036 Pop and yummy on the same edge at credit_cnt 3 -> credit_cnt stays 3; push and pop on the same edge at fifo_cnt 5 -> fifo_cnt stays 5.
REQ-037 Assert reset asynchronously with fifo_cnt 6 and valid_out high -> outputs reach REQ-028 values without a clock edge; after release, first pushed flit is the first sent.
